fft_frame_buffer: RTL and testbench

FFT_FRAME_BUFFER -- requirements
Module: fft_frame_buffer

---
 rtl/fft_pkg.sv | 36 +++
 rtl/fft_bank.sv | 24 ++
 rtl/fft_frame_buffer.sv | 186 ++++++++++++++++++
 tb/tb_fft_frame_buffer.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fft_pkg.sv
// Shared types for the FFT ping-pong frame buffer.
// Bank/FSM state encodings and the bit-reverse helper.
package fft_pkg;

  typedef enum logic [1:0] {
    B_EMPTY,
    B_FILLING,
    B_FULL,
    B_DRAINING
  } bank_st_t;

  typedef enum logic [1:0] {
    W_FILL,
    W_PAD,
    W_WAIT
  } wr_st_t;

  typedef enum logic {
    R_IDLE,
    R_DRAIN
  } rd_st_t;

  // Reverses the low w bits of v; upper bits return zero.
  function automatic logic [31:0] bitreverse(
    input logic [31:0] v,
    input int          w
  );
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < 32; i++) begin
      if (i < w) r[i] = v[w-1-i];
    end
    return r;
  endfunction

endpackage

// File: rtl/fft_bank.sv
// One DEPTH x WIDTH sample bank.
// Synchronous write port, combinational read port.
module fft_bank #(
  parameter int WIDTH  = 64,
  parameter int DEPTH  = 100,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clock,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [WIDTH-1:0]  rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clock) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/fft_frame_buffer.sv
// Ping-pong frame buffer feeding an FFT core.
// Two banks, zero-padding on early in_last, optional bit-reversed drain.
module fft_frame_buffer
  import fft_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int DEPTH = 100,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WIDTH-1:0]  in_data,
  input  logic              in_last,
  input  logic              rd_bitrev,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WIDTH-1:0]  out_data,
  output logic [ADDR_W-1:0] out_index,
  output logic              out_last,
  output logic              out_padded,
  output logic [15:0]       frame_count
);

  localparam bit POW2 = (DEPTH == 2**ADDR_W);
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH-1);

  bank_st_t          bst_q [2];
  bank_st_t          bst_d [2];
  logic [1:0]        pad_q, pad_d;
  wr_st_t            wst_q, wst_d;
  logic              wbank_q, wbank_d;
  logic [ADDR_W-1:0] wptr_q, wptr_d;
  rd_st_t            rdst_q, rdst_d;
  logic              rbank_q, rbank_d;
  logic [ADDR_W-1:0] rptr_q, rptr_d;
  logic              rbrev_q, rbrev_d;
  logic [15:0]       fcnt_q, fcnt_d;

  logic              in_fire, out_fire, rd_done;
  logic              wr_en, wr_last, other, other_free;
  logic              close, take;
  logic [ADDR_W-1:0] rev;
  logic [WIDTH-1:0]  wdata;
  logic [WIDTH-1:0]  rdata [2];

  assign in_ready   = (wst_q == W_FILL);
  assign out_valid  = (rdst_q == R_DRAIN);
  assign in_fire    = in_valid && in_ready;
  assign out_fire   = out_valid && out_ready;
  assign rd_done    = out_fire && (rptr_q == LAST);
  assign wr_en      = in_fire || (wst_q == W_PAD);
  assign wr_last    = (wptr_q == LAST);
  assign other      = ~wbank_q;
  // A bank being freed this edge counts as free for the writer.
  assign other_free = (bst_q[other] == B_EMPTY) ||
                      (rd_done && (rbank_q == other));
  assign wdata      = (wst_q == W_PAD) ? '0 : in_data;

  always_comb begin
    rev       = ADDR_W'(bitreverse(32'(rptr_q), ADDR_W));
    out_index = (rbrev_q && POW2) ? rev : rptr_q;
  end

  assign out_data    = rdata[rbank_q];
  assign out_last    = out_valid && (rptr_q == LAST);
  assign out_padded  = out_valid && pad_q[rbank_q];
  assign frame_count = fcnt_q;

  for (genvar g = 0; g < 2; g++) begin : g_bank
    fft_bank #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH),
      .ADDR_W(ADDR_W)
    ) u_bank (
      .clock(clock),
      .we   (wr_en && (wbank_q == 1'(g))),
      .waddr(wptr_q),
      .wdata(wdata),
      .raddr(out_index),
      .rdata(rdata[g])
    );
  end

  always_comb begin
    bst_d   = bst_q;
    pad_d   = pad_q;
    wst_d   = wst_q;
    wbank_d = wbank_q;
    wptr_d  = wptr_q;
    rdst_d  = rdst_q;
    rbank_d = rbank_q;
    rptr_d  = rptr_q;
    rbrev_d = rbrev_q;
    fcnt_d  = fcnt_q;
    close   = 1'b0;
    take    = 1'b0;

    if (rd_done) begin
      bst_d[rbank_q] = B_EMPTY;
      fcnt_d         = fcnt_q + 16'd1;
      rptr_d         = '0;
      if (bst_q[~rbank_q] == B_FULL) begin
        bst_d[~rbank_q] = B_DRAINING;
        rbank_d         = ~rbank_q;
        rbrev_d         = rd_bitrev;
      end else begin
        rdst_d = R_IDLE;
      end
    end else if (out_fire) begin
      rptr_d = rptr_q + 1'b1;
    end else if (rdst_q == R_IDLE) begin
      if (bst_q[0] == B_FULL || bst_q[1] == B_FULL) begin
        rbank_d        = (bst_q[0] == B_FULL) ? 1'b0 : 1'b1;
        bst_d[rbank_d] = B_DRAINING;
        rdst_d         = R_DRAIN;
        rptr_d         = '0;
        rbrev_d        = rd_bitrev;
      end
    end

    unique case (wst_q)
      W_FILL: begin
        if (in_fire) begin
          bst_d[wbank_q] = B_FILLING;
          if (wr_last) begin
            close = 1'b1;
          end else begin
            wptr_d = wptr_q + 1'b1;
            if (in_last) wst_d = W_PAD;
          end
        end
      end
      W_PAD: begin
        if (wr_last) close = 1'b1;
        else wptr_d = wptr_q + 1'b1;
      end
      W_WAIT: take = other_free;
      default: wst_d = W_FILL;
    endcase

    if (close) begin
      bst_d[wbank_q] = B_FULL;
      pad_d[wbank_q] = (wst_q == W_PAD);
      wptr_d         = '0;
      if (other_free) take = 1'b1;
      else wst_d = W_WAIT;
    end

    if (take) begin
      bst_d[other] = B_FILLING;
      wbank_d      = other;
      wptr_d       = '0;
      wst_d        = W_FILL;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      bst_q[0] <= B_EMPTY;
      bst_q[1] <= B_EMPTY;
      pad_q    <= '0;
      wst_q    <= W_FILL;
      wbank_q  <= 1'b0;
      wptr_q   <= '0;
      rdst_q   <= R_IDLE;
      rbank_q  <= 1'b0;
      rptr_q   <= '0;
      rbrev_q  <= 1'b0;
      fcnt_q   <= '0;
    end else begin
      bst_q    <= bst_d;
      pad_q    <= pad_d;
      wst_q    <= wst_d;
      wbank_q  <= wbank_d;
      wptr_q   <= wptr_d;
      rdst_q   <= rdst_d;
      rbank_q  <= rbank_d;
      rptr_q   <= rptr_d;
      rbrev_q  <= rbrev_d;
      fcnt_q   <= fcnt_d;
    end
  end

endmodule

// File: tb/tb_fft_frame_buffer.sv
// Randomized bench for fft_frame_buffer against a frame-queue model.
// DEPTH=8 instance for main tests, DEPTH=6 for the non-pow2 fallback.
module tb_fft_frame_buffer;

  localparam int W = 16;
  localparam int D = 8;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  logic         in_valid, in_ready, in_last, rd_bitrev;
  logic         out_valid, out_ready, out_last, out_padded;
  logic [W-1:0] in_data, out_data;
  logic [2:0]   out_index;
  logic [15:0]  frame_count;

  logic         in6_valid, in6_ready, in6_last, rd_bitrev6;
  logic         out6_valid, out6_ready, out6_last, out6_padded;
  logic [W-1:0] in6_data, out6_data;
  logic [2:0]   out6_index;
  logic [15:0]  frame_count6;

  fft_frame_buffer #(.WIDTH(W), .DEPTH(D)) u_dut (
    .clock(clock), .reset_n(reset_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_last(in_last),
    .rd_bitrev(rd_bitrev),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_index(out_index),
    .out_last(out_last), .out_padded(out_padded),
    .frame_count(frame_count)
  );

  fft_frame_buffer #(.WIDTH(W), .DEPTH(6)) u_dut6 (
    .clock(clock), .reset_n(reset_n),
    .in_valid(in6_valid), .in_ready(in6_ready),
    .in_data(in6_data), .in_last(in6_last),
    .rd_bitrev(rd_bitrev6),
    .out_valid(out6_valid), .out_ready(out6_ready),
    .out_data(out6_data), .out_index(out6_index),
    .out_last(out6_last), .out_padded(out6_padded),
    .frame_count(frame_count6)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  typedef struct packed {
    logic           pad;
    logic [D*W-1:0] d;
  } frame_t;

  frame_t       fq[$];
  logic [W-1:0] cur[$];
  int           ridx = 0;
  int           fc = 0;
  bit           rbrev_m = 0;
  bit           in_fired = 0;

  function automatic int order(int i);
    if (!rbrev_m) return i;
    return ((i & 1) << 2) | (i & 2) | ((i >> 2) & 1);
  endfunction

  task automatic model_clear();
    fq.delete();
    cur.delete();
    ridx = 0;
    fc = 0;
  endtask

  task automatic model_push(logic [W-1:0] v, logic last);
    frame_t f;
    cur.push_back(v);
    if (cur.size() == D || last) begin
      f.pad = (cur.size() < D);
      while (cur.size() < D) cur.push_back('0);
      for (int i = 0; i < D; i++) f.d[i*W +: W] = cur[i];
      fq.push_back(f);
      cur.delete();
    end
  endtask

  task automatic model_pop();
    int k;
    if (fq.size() == 0) begin
      check("spurious_out", 32'(out_valid), 0);
    end else begin
      if (ridx == 0) rbrev_m = rd_bitrev;
      k = order(ridx);
      check("out_index", 32'(out_index), 32'(k));
      check("out_data", 32'(out_data), 32'(fq[0].d[k*W +: W]));
      check("out_last", 32'(out_last), 32'(ridx == D-1));
      check("out_padded", 32'(out_padded), 32'(fq[0].pad));
      ridx++;
      if (ridx == D) begin
        ridx = 0;
        void'(fq.pop_front());
        fc++;
      end
    end
  endtask

  task automatic tick();
    #1;
    in_fired = in_valid && in_ready;
    if (out_valid && out_ready) model_pop();
    if (in_fired) model_push(in_data, in_last);
    @(negedge clock);
  endtask

  task automatic send(logic [W-1:0] v, logic last);
    int n = 0;
    in_valid = 1'b1;
    in_data  = v;
    in_last  = last;
    do begin
      tick();
      n++;
    end while (!in_fired && n < 100);
    if (!in_fired) check("send_timeout", 32'(in_fired), 1);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    out_ready = 1'b1;
    while ((fq.size() != 0 || out_valid) && n < 300) begin
      tick();
      n++;
    end
    if (n >= 300) check("drain_timeout", 32'(fq.size()), 0);
  endtask

  task automatic check_idle(string tag);
    check({tag, "_in_ready"}, 32'(in_ready), 1);
    check({tag, "_out_valid"}, 32'(out_valid), 0);
    check({tag, "_frame_count"}, 32'(frame_count), 0);
  endtask

  initial begin
    int n, k;
    in_valid = 0; in_data = '0; in_last = 0;
    rd_bitrev = 0; out_ready = 0;
    in6_valid = 0; in6_data = '0; in6_last = 0;
    rd_bitrev6 = 0; out6_ready = 0;

    @(negedge clock);
    check_idle("rst");
    check("rst_out_last", 32'(out_last), 0);
    check("rst_out_padded", 32'(out_padded), 0);
    check("rst_out_index", 32'(out_index), 0);
    reset_n = 1'b1;
    model_clear();
    @(negedge clock);

    // linear frame
    rd_bitrev = 0;
    out_ready = 1;
    for (int i = 1; i <= 8; i++) send(16'(i), 1'b0);
    drain();
    check("fc_linear", 32'(frame_count), 1);

    // bit-reversed frame
    rd_bitrev = 1;
    for (int i = 0; i < 8; i++) send(16'(i), 1'b0);
    drain();
    check("fc_bitrev", 32'(frame_count), 32'(fc));

    // early in_last pads with zeros
    rd_bitrev = 0;
    send(16'd1, 1'b0);
    send(16'd2, 1'b0);
    send(16'd3, 1'b1);
    n = 0;
    while (!in_ready && n < 20) begin
      tick();
      n++;
    end
    check("pad_cycles", 32'(n), 5);
    drain();
    check("fc_pad", 32'(frame_count), 32'(fc));

    // both banks full with a stalled consumer
    out_ready = 0;
    for (int i = 0; i < 16; i++) send(16'(16'h40 + i), 1'b0);
    check("full_in_ready", 32'(in_ready), 0);
    check("full_out_valid", 32'(out_valid), 1);
    out_ready = 1;
    tick();
    out_ready = 0;
    check("one_pop_in_ready", 32'(in_ready), 0);
    check("one_pop_fc", 32'(frame_count), 32'(fc));
    out_ready = 1;
    repeat (7) tick();
    out_ready = 0;
    check("release_in_ready", 32'(in_ready), 1);
    check("gapless_valid", 32'(out_valid), 1);
    check("release_fc", 32'(frame_count), 32'(fc));
    drain();

    // random traffic
    for (int ph = 0; ph < 2; ph++) begin
      rd_bitrev = 1'(ph);
      for (int c = 0; c < 1500; c++) begin
        in_valid  = ($urandom % 4) != 0;
        in_data   = 16'($urandom);
        in_last   = ($urandom % 12) == 0;
        out_ready = ($urandom % 4) != 0;
        tick();
      end
      in_valid  = 0;
      in_last   = 0;
      out_ready = 1;
      if (cur.size() != 0) send(16'h0, 1'b1);
      drain();
      check("fc_random", 32'(frame_count), 32'(fc % 65536));
    end

    // reset mid-frame
    rd_bitrev = 0;
    out_ready = 1;
    for (int i = 0; i < 5; i++) send(16'(16'h90 + i), 1'b0);
    reset_n = 1'b0;
    #1;
    check_idle("mid_rst");
    @(negedge clock);
    reset_n = 1'b1;
    model_clear();
    check_idle("post_rst");
    for (int i = 0; i < 8; i++) send(16'(16'hA0 + i), 1'b0);
    drain();
    check("fc_after_rst", 32'(frame_count), 1);

    // non-power-of-two depth ignores rd_bitrev
    rd_bitrev6 = 1;
    out6_ready = 1;
    for (int i = 0; i < 6; i++) begin
      in6_valid = 1;
      in6_data  = 16'(16'h100 + i);
      check("d6_in_ready", 32'(in6_ready), 1);
      @(negedge clock);
    end
    in6_valid = 0;
    n = 0;
    k = 0;
    while (k < 6 && n < 50) begin
      if (out6_valid) begin
        check("d6_index", 32'(out6_index), 32'(k));
        check("d6_data", 32'(out6_data), 32'(16'h100 + k));
        check("d6_last", 32'(out6_last), 32'(k == 5));
        k++;
      end
      n++;
      @(negedge clock);
    end
    check("d6_count", 32'(k), 6);
    check("d6_fc", 32'(frame_count6), 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
